// File: rtl/control_rw_flow_pkg.sv
// Shared definitions for the read/transmit flow controller: state encoding,
// transfer-mode constants and the default WAIT timeout.
package control_rw_flow_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CHECK = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;

  localparam logic MODE_SERIAL   = 1'b0;
  localparam logic MODE_PARALLEL = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/control_rw_flow_timeout_counter.sv
// Cycle counter used while the controller waits on the transceiver.
// done is high on the LIMIT-th consecutive enabled cycle since the last clear.
module timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] count;

  // Count enabled cycles; clear wins over enable so each WAIT visit starts at zero.
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CW'(1);
    end
  end

  // Terminal count: this is the last cycle allowed before abort.
  always_comb begin
    done = (count == CW'(LIMIT - 1));
  end

endmodule

// File: rtl/control_rw_flow.sv
// Read/transmit flow controller: pops one word from the data buffer, starts the
// transceiver, waits for it to finish, and repeats while the key stays active.
//
// Handshake: RdEn and TxStart are one-cycle strobes with no back-pressure.
// TxBusy is the transceiver's completion signal; it is expected to rise the
// cycle after TxStart and fall once the word has gone out.
module control_rw_flow
  import control_rw_flow_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Active,
  input  logic                   Mode,
  input  logic                   Empty,
  input  logic                   TxBusy,
  output logic                   RdEn,
  output logic                   TxStart,
  output logic                   TxMode,
  output logic                   Busy,
  output logic [COUNT_WIDTH-1:0] WordCount,
  output logic                   TimeoutErr,
  output logic [2:0]             fsm_state
);

  state_t state;
  state_t state_next;
  logic   wait_done;
  logic   wait_clear;
  logic   wait_enable;

  assign wait_clear  = (state != ST_WAIT);
  assign wait_enable = (state == ST_WAIT) && TxBusy;

  timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .done   (wait_done)
  );

  // Next-state logic; Active dropping mid-word is only honoured back in CHECK.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (Active) state_next = ST_CHECK;
      ST_CHECK: begin
        if (!Active)                  state_next = ST_IDLE;
        else if (!Empty && !TxBusy)   state_next = ST_READ;
      end
      ST_READ:  state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!TxBusy)        state_next = ST_CHECK;
        else if (wait_done) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, strobes and session bookkeeping; strobes are registered so a reset
  // edge cancels any strobe that would otherwise follow it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      RdEn       <= 1'b0;
      TxStart    <= 1'b0;
      TxMode     <= MODE_SERIAL;
      WordCount  <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      state   <= state_next;
      RdEn    <= (state_next == ST_READ);
      TxStart <= (state_next == ST_START);
      if (state == ST_IDLE && Active) begin
        TxMode     <= Mode;
        WordCount  <= '0;
        TimeoutErr <= 1'b0;
      end
      if (state == ST_WAIT && !TxBusy && WordCount != '1) begin
        WordCount <= WordCount + COUNT_WIDTH'(1);
      end
      if (state == ST_WAIT && TxBusy && wait_done) begin
        TimeoutErr <= 1'b1;
      end
    end
  end

  // Status decode.
  always_comb begin
    Busy      = (state != ST_IDLE);
    fsm_state = state;
  end

endmodule

// File: doc/control_rw_flow.md
CONTROL_RW_FLOW -- requirements
Module: control_rw_flow

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before abort.
REQ-002 Parameter COUNT_WIDTH, default 8: width of WordCount.
REQ-003 Clk  input  1  single clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Active  input  1  key-accepted flag from the key decoder stage.
REQ-006 Mode  input  1  transfer mode from the key decoder: 0 = serial, 1 = parallel.
REQ-007 Empty  input  1  data buffer empty flag.
REQ-008 TxBusy  input  1  transceiver busy; transceiver raises it the cycle after TxStart and holds it until the word is sent.
REQ-009 RdEn  output  1  one-cycle pop strobe to the data buffer.
REQ-010 TxStart  output  1  one-cycle start strobe to the transceiver.
REQ-011 TxMode  output  1  latched mode, stable for the whole session.
REQ-012 Busy  output  1  high whenever state is not IDLE.
REQ-013 WordCount  output  COUNT_WIDTH  words completed in the current session.
REQ-014 TimeoutErr  output  1  sticky timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, READ, START and WAIT, all registered.
REQ-016 IDLE: on Active=1, go to CHECK, latch Mode into TxMode, clear WordCount and TimeoutErr.
REQ-017 CHECK: Active=0 -> IDLE; Active=1, Empty=0 and TxBusy=0 -> READ; otherwise stay.
REQ-018 READ SHALL assert RdEn for exactly one cycle, then go to START; buffer data is valid the cycle after RdEn.
REQ-019 START SHALL assert TxStart for exactly one cycle, then go to WAIT.
REQ-020 WAIT: TxBusy=0 -> increment WordCount and go to CHECK; otherwise stay and count cycles.
REQ-021 WAIT SHALL abort to IDLE when its cycle counter reaches TIMEOUT_CYCLES; TimeoutErr SHALL set and WordCount SHALL NOT increment.
REQ-022 RdEn and TxStart SHALL never be high in the same cycle.
REQ-023 Latency: from Active rising with Empty=0 and TxBusy=0, RdEn SHALL assert 2 cycles later and TxStart 3 cycles later.
REQ-024 Mode changes while not IDLE SHALL be ignored; TxMode changes only on the IDLE->CHECK transition.
REQ-025 Active falling during READ, START or WAIT SHALL let the current word complete; the return to IDLE happens from CHECK.
REQ-026 WordCount SHALL saturate at all-ones and hold there; it holds its value in IDLE until the next session starts.
REQ-027 TimeoutErr SHALL stay high until the next IDLE->CHECK transition or Reset.
REQ-028 Empty=1 in CHECK SHALL hold CHECK indefinitely; there is no timeout in CHECK.

Reset
REQ-029 Reset SHALL take priority over all other inputs and return the block to IDLE on the next edge.
REQ-030 After Reset: RdEn=0, TxStart=0, TxMode=0, Busy=0, WordCount=0, TimeoutErr=0, WAIT counter=0.
REQ-031 Reset asserted mid-transfer SHALL drop any pending strobe; no RdEn or TxStart pulse SHALL follow it.

Structure
REQ-032 A shared controller package SHALL hold the state encoding typedef, the MODE_SERIAL and MODE_PARALLEL constants, and the default TIMEOUT_CYCLES.
REQ-033 The WAIT cycle counter SHALL be a separate sub-module, timeout_counter, with a clear input, an enable input and a terminal-count output.

Verification
REQ-034 Reset held 15 ns, then Active=1, Mode=1, Empty=0, TxBusy=0 -> RdEn high at cycle 2, TxStart high at cycle 3, TxMode=1, Busy=1.
REQ-035 Three words, TxBusy high for 8 cycles after each TxStart (serial) -> WordCount=3, exactly 3 RdEn and 3 TxStart pulses.
REQ-036 Active dropped during WAIT -> current word completes, WordCount increments, then IDLE with Busy=0.
REQ-037 TxBusy stuck at 1 after TxStart -> TimeoutErr=1 after 64 WAIT cycles, state IDLE, WordCount unchanged.
REQ-038 Empty=1 for 20 cycles in CHECK -> no RdEn; Mode toggled during the session -> TxMode unchanged.
REQ-039 Reset pulsed during START -> no TxStart pulse, and all outputs at reset values on the next cycle.
